// File: rtl/axi_rd_arbiter_if.sv
// Bus bundles for the two-master read arbiter: a simple valid/ready read
// request/response port per master, and the AXI4 read channels to the slave.

interface rd_req_if;
  logic [63:0] ar_addr;
  logic        ar_valid;
  logic        ar_ready;
  logic [63:0] r_data;
  logic [1:0]  r_resp;
  logic        r_valid;
  logic        r_ready;

  modport master (
    output ar_addr, ar_valid, r_ready,
    input  ar_ready, r_data, r_resp, r_valid
  );

  modport slave (
    input  ar_addr, ar_valid, r_ready,
    output ar_ready, r_data, r_resp, r_valid
  );
endinterface

interface axi_rd_if;
  logic [3:0]  ar_id;
  logic [63:0] ar_addr;
  logic [7:0]  ar_len;
  logic [2:0]  ar_size;
  logic [1:0]  ar_burst;
  logic [3:0]  ar_cache;
  logic [2:0]  ar_prot;
  logic [3:0]  ar_qos;
  logic        ar_valid;
  logic        ar_ready;
  logic [3:0]  r_id;
  logic [63:0] r_data;
  logic [1:0]  r_resp;
  logic        r_last;
  logic        r_valid;
  logic        r_ready;

  modport master (
    output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_cache, ar_prot,
           ar_qos, ar_valid, r_ready,
    input  ar_ready, r_id, r_data, r_resp, r_last, r_valid
  );

  modport slave (
    input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_cache, ar_prot,
           ar_qos, ar_valid, r_ready,
    output ar_ready, r_id, r_data, r_resp, r_last, r_valid
  );
endinterface

// File: rtl/axi_rd_arbiter.sv
// Round-robin arbiter sharing one AXI4 read slave between instruction fetch
// (ID 1) and data memory (ID 0); one single-beat read in flight, with watchdog.

module axi_rd_arbiter #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic clk,
  input  logic rst,
  rd_req_if.slave  i_bus,
  rd_req_if.slave  d_bus,
  axi_rd_if.master m_bus
);

  localparam logic [3:0] ID_FETCH = 4'b0001;
  localparam logic [3:0] ID_DATA  = 4'b0000;
  localparam logic [7:0] WD_LAST  = 8'(TIMEOUT_CYC - 1);
  localparam logic [1:0] SLVERR   = 2'b10;

  typedef enum logic [1:0] {IDLE, ADDR, DATA, ERR} state_t;

  state_t      state;
  logic        owner_fetch;
  logic        last_fetch;
  logic        ar_vld;
  logic [63:0] addr_r;
  logic [3:0]  id_r;
  logic [7:0]  wd_cnt;

  logic        grant_i;
  logic        grant_d;
  logic        own_r_ready;
  logic        up_vld;
  logic [63:0] up_data;
  logic [1:0]  up_resp;
  logic        r_ready_m;

  // A wrong ID or a missing last flag means the beat is not ours: flag SLVERR.
  function automatic logic [1:0] checked_resp(input logic [3:0] rid,
                                              input logic [3:0] exp_id,
                                              input logic       rlast,
                                              input logic [1:0] resp);
    if ((rid != exp_id) || !rlast) return SLVERR;
    return resp;
  endfunction

  // Round-robin: on conflict the master not granted last time wins.
  always_comb begin
    grant_i = !rst && (state == IDLE) && i_bus.ar_valid &&
              (!d_bus.ar_valid || !last_fetch);
    grant_d = !rst && (state == IDLE) && d_bus.ar_valid &&
              (!i_bus.ar_valid || last_fetch);
  end

  assign own_r_ready = owner_fetch ? i_bus.r_ready : d_bus.r_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      owner_fetch <= 1'b0;
      last_fetch  <= 1'b0;
      ar_vld      <= 1'b0;
      addr_r      <= '0;
      id_r        <= '0;
      wd_cnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_i || grant_d) begin
            state       <= ADDR;
            ar_vld      <= 1'b1;
            owner_fetch <= grant_i;
            last_fetch  <= grant_i;
            addr_r      <= grant_i ? i_bus.ar_addr : d_bus.ar_addr;
            id_r        <= grant_i ? ID_FETCH : ID_DATA;
          end
        end
        ADDR: begin
          if (m_bus.ar_ready) begin
            state  <= DATA;
            ar_vld <= 1'b0;
            wd_cnt <= '0;
          end
        end
        DATA: begin
          // A beat present in the final watchdog cycle still takes precedence.
          if (m_bus.r_valid) begin
            if (own_r_ready) state <= IDLE;
          end else begin
            wd_cnt <= wd_cnt + 8'd1;
            if (wd_cnt == WD_LAST) state <= ERR;
          end
        end
        ERR: begin
          if (own_r_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outside DATA/ERR the R channel is drained: beats are accepted, never forwarded.
  always_comb begin
    up_vld    = 1'b0;
    up_data   = '0;
    up_resp   = 2'b00;
    r_ready_m = 1'b1;
    case (state)
      DATA: begin
        up_vld    = m_bus.r_valid;
        up_data   = m_bus.r_data;
        up_resp   = checked_resp(m_bus.r_id, id_r, m_bus.r_last, m_bus.r_resp);
        r_ready_m = own_r_ready;
      end
      ERR: begin
        up_vld    = 1'b1;
        up_resp   = SLVERR;
        r_ready_m = 1'b0;
      end
      default: r_ready_m = 1'b1;
    endcase
  end

  assign i_bus.ar_ready = grant_i;
  assign d_bus.ar_ready = grant_d;

  assign i_bus.r_valid = owner_fetch && up_vld;
  assign i_bus.r_data  = owner_fetch ? up_data : 64'd0;
  assign i_bus.r_resp  = owner_fetch ? up_resp : 2'b00;
  assign d_bus.r_valid = !owner_fetch && up_vld;
  assign d_bus.r_data  = owner_fetch ? 64'd0 : up_data;
  assign d_bus.r_resp  = owner_fetch ? 2'b00 : up_resp;

  assign m_bus.ar_id    = id_r;
  assign m_bus.ar_addr  = addr_r;
  assign m_bus.ar_valid = ar_vld;
  assign m_bus.ar_len   = 8'd0;
  assign m_bus.ar_size  = 3'b011;
  assign m_bus.ar_burst = 2'b01;
  assign m_bus.ar_cache = 4'b0010;
  assign m_bus.ar_prot  = 3'b000;
  assign m_bus.ar_qos   = 4'h0;
  assign m_bus.r_ready  = r_ready_m;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed bench for axi_rd_arbiter: a vector table of single reads plus
// sequences for contention, back-pressure, watchdog and mid-transaction reset.

module tb_axi_rd_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rd_req_if i_bus ();
  rd_req_if d_bus ();
  axi_rd_if m_bus ();

  axi_rd_arbiter #(.TIMEOUT_CYC(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .i_bus (i_bus),
    .d_bus (d_bus),
    .m_bus (m_bus)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        fetch;
    logic [63:0] addr;
    logic [63:0] rdata;
    logic [3:0]  rid;
    logic        rlast;
    logic [1:0]  rresp;
    logic [3:0]  exp_id;
    logic [1:0]  exp_resp;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    i_bus.ar_valid = 1'b0; i_bus.ar_addr = '0; i_bus.r_ready = 1'b1;
    d_bus.ar_valid = 1'b0; d_bus.ar_addr = '0; d_bus.r_ready = 1'b1;
    m_bus.ar_ready = 1'b0; m_bus.r_valid = 1'b0; m_bus.r_id = '0;
    m_bus.r_data = '0; m_bus.r_resp = '0; m_bus.r_last = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    check({tag, " m_ar_valid"}, m_bus.ar_valid, 0);
    check({tag, " i_r_valid"},  i_bus.r_valid, 0);
    check({tag, " d_r_valid"},  d_bus.r_valid, 0);
    check({tag, " i_ar_ready"}, i_bus.ar_ready, 0);
    check({tag, " d_ar_ready"}, d_bus.ar_ready, 0);
    check({tag, " m_ar_id"},    m_bus.ar_id, 0);
    check({tag, " m_ar_addr"},  m_bus.ar_addr, 0);
    check({tag, " m_r_ready"},  m_bus.r_ready, 1);
  endtask

  task automatic beat(input logic [63:0] data, input logic [3:0] id,
                      input logic last, input logic [1:0] resp);
    m_bus.r_valid = 1'b1; m_bus.r_data = data; m_bus.r_id = id;
    m_bus.r_last = last; m_bus.r_resp = resp;
  endtask

  initial begin
    vecs[0] = '{1'b1, 64'h0000_0000_8000_0000, 64'hDEAD_BEEF_0123_4567, 4'd1, 1'b1, 2'b00, 4'd1, 2'b00};
    vecs[1] = '{1'b0, 64'h0000_0000_8000_1008, 64'h0BAD_F00D_CAFE_0001, 4'd0, 1'b1, 2'b00, 4'd0, 2'b00};
    vecs[2] = '{1'b0, 64'h0000_0000_8000_2000, 64'h1111_2222_3333_4444, 4'd1, 1'b1, 2'b00, 4'd0, 2'b10};
    vecs[3] = '{1'b1, 64'h0000_0000_8000_0040, 64'h5555_6666_7777_8888, 4'd1, 1'b0, 2'b00, 4'd1, 2'b10};
    vecs[4] = '{1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 64'hAAAA_BBBB_CCCC_DDDD, 4'd1, 1'b1, 2'b11, 4'd1, 2'b11};
    vecs[5] = '{1'b0, 64'h0000_0000_0000_0000, 64'h0123_0000_0000_3210, 4'd0, 1'b1, 2'b01, 4'd0, 2'b01};

    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_reset("reset");
    check("ar_len", m_bus.ar_len, 0);
    check("ar_size", m_bus.ar_size, 3'b011);
    check("ar_burst", m_bus.ar_burst, 2'b01);
    check("ar_cache", m_bus.ar_cache, 4'b0010);
    check("ar_prot", m_bus.ar_prot, 0);
    check("ar_qos", m_bus.ar_qos, 0);
    step();

    // Persistent contention from reset: fetch first, then alternating.
    i_bus.ar_valid = 1'b1; i_bus.ar_addr = 64'h8000_0A00;
    d_bus.ar_valid = 1'b1; d_bus.ar_addr = 64'h8000_0D00;
    for (int r = 0; r < 4; r++) begin
      logic f;
      f = (r % 2 == 0);
      #1;
      check("rr i_ar_ready", i_bus.ar_ready, f);
      check("rr d_ar_ready", d_bus.ar_ready, !f);
      step();
      m_bus.ar_ready = 1'b1;
      #1;
      check("rr m_ar_valid", m_bus.ar_valid, 1);
      check("rr m_ar_id", m_bus.ar_id, f ? 4'd1 : 4'd0);
      check("rr m_ar_addr", m_bus.ar_addr, f ? 64'h8000_0A00 : 64'h8000_0D00);
      check("rr ar_ready in ADDR", {i_bus.ar_ready, d_bus.ar_ready}, 0);
      step();
      m_bus.ar_ready = 1'b0;
      beat(64'h1000 + 64'(r), f ? 4'd1 : 4'd0, 1'b1, 2'b00);
      #1;
      check("rr owner r_valid", f ? i_bus.r_valid : d_bus.r_valid, 1);
      check("rr other r_valid", f ? d_bus.r_valid : i_bus.r_valid, 0);
      check("rr owner r_data", f ? i_bus.r_data : d_bus.r_data, 64'h1000 + 64'(r));
      step();
      m_bus.r_valid = 1'b0;
    end
    i_bus.ar_valid = 1'b0;
    d_bus.ar_valid = 1'b0;
    step();

    // Table of single-master reads.
    for (int v = 0; v < 6; v++) begin
      if (vecs[v].fetch) begin
        i_bus.ar_valid = 1'b1; i_bus.ar_addr = vecs[v].addr;
      end else begin
        d_bus.ar_valid = 1'b1; d_bus.ar_addr = vecs[v].addr;
      end
      #1;
      check("vec i_ar_ready", i_bus.ar_ready, vecs[v].fetch);
      check("vec d_ar_ready", d_bus.ar_ready, !vecs[v].fetch);
      step();
      i_bus.ar_valid = 1'b0; d_bus.ar_valid = 1'b0;
      m_bus.ar_ready = 1'b1;
      #1;
      check("vec m_ar_valid", m_bus.ar_valid, 1);
      check("vec m_ar_id", m_bus.ar_id, vecs[v].exp_id);
      check("vec m_ar_addr", m_bus.ar_addr, vecs[v].addr);
      step();
      m_bus.ar_ready = 1'b0;
      beat(vecs[v].rdata, vecs[v].rid, vecs[v].rlast, vecs[v].rresp);
      #1;
      check("vec owner r_valid", vecs[v].fetch ? i_bus.r_valid : d_bus.r_valid, 1);
      check("vec other r_valid", vecs[v].fetch ? d_bus.r_valid : i_bus.r_valid, 0);
      check("vec owner r_data", vecs[v].fetch ? i_bus.r_data : d_bus.r_data, vecs[v].rdata);
      check("vec owner r_resp", vecs[v].fetch ? i_bus.r_resp : d_bus.r_resp, vecs[v].exp_resp);
      check("vec other r_data", vecs[v].fetch ? d_bus.r_data : i_bus.r_data, 0);
      check("vec addr held in DATA", m_bus.ar_addr, vecs[v].addr);
      check("vec id held in DATA", m_bus.ar_id, vecs[v].exp_id);
      check("vec m_r_ready", m_bus.r_ready, 1);
      step();
      m_bus.r_valid = 1'b0;
      #1;
      check("vec m_ar_valid after", m_bus.ar_valid, 0);
      check("vec owner r_valid after", vecs[v].fetch ? i_bus.r_valid : d_bus.r_valid, 0);
      step();
    end

    // Owner back-pressure for 5 cycles, then a stray beat in IDLE.
    i_bus.ar_valid = 1'b1; i_bus.ar_addr = 64'h8000_0100;
    step();
    i_bus.ar_valid = 1'b0; m_bus.ar_ready = 1'b1;
    step();
    m_bus.ar_ready = 1'b0; i_bus.r_ready = 1'b0;
    beat(64'hFEED_0000_0000_0005, 4'd1, 1'b1, 2'b00);
    for (int k = 0; k < 5; k++) begin
      #1;
      check("bp m_r_ready low", m_bus.r_ready, 0);
      check("bp i_r_valid held", i_bus.r_valid, 1);
      step();
    end
    i_bus.r_ready = 1'b1;
    #1;
    check("bp m_r_ready release", m_bus.r_ready, 1);
    check("bp i_r_data", i_bus.r_data, 64'hFEED_0000_0000_0005);
    step();
    #1;
    check("stray i_r_valid", i_bus.r_valid, 0);
    check("stray d_r_valid", d_bus.r_valid, 0);
    check("stray m_r_ready", m_bus.r_ready, 1);
    m_bus.r_valid = 1'b0;
    step();

    // Watchdog: silent slave, ERR exactly 8 cycles after DATA entry.
    d_bus.ar_valid = 1'b1; d_bus.ar_addr = 64'h8000_3000; d_bus.r_ready = 1'b0;
    step();
    d_bus.ar_valid = 1'b0; m_bus.ar_ready = 1'b1;
    step();
    m_bus.ar_ready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      #1;
      check("wd d_r_valid before timeout", d_bus.r_valid, 0);
      step();
    end
    #1;
    check("wd err d_r_valid", d_bus.r_valid, 1);
    check("wd err d_r_resp", d_bus.r_resp, 2'b10);
    check("wd err d_r_data", d_bus.r_data, 0);
    check("wd err m_r_ready", m_bus.r_ready, 0);
    check("wd err i_r_valid", i_bus.r_valid, 0);
    step();
    d_bus.r_ready = 1'b1;
    #1;
    check("wd err held", d_bus.r_valid, 1);
    step();
    beat(64'h0BAD_0BAD_0BAD_0BAD, 4'd0, 1'b1, 2'b00);
    #1;
    check("wd late m_r_ready", m_bus.r_ready, 1);
    check("wd late d_r_valid", d_bus.r_valid, 0);
    step();
    m_bus.r_valid = 1'b0;
    step();

    // Beat arrives in the last watchdog cycle: normal completion, no ERR.
    d_bus.ar_valid = 1'b1; d_bus.ar_addr = 64'h8000_3100;
    step();
    d_bus.ar_valid = 1'b0; m_bus.ar_ready = 1'b1;
    step();
    m_bus.ar_ready = 1'b0;
    for (int k = 0; k < 7; k++) begin
      #1;
      check("edge d_r_valid silent", d_bus.r_valid, 0);
      step();
    end
    beat(64'h7777_7777_0000_0007, 4'd0, 1'b1, 2'b00);
    #1;
    check("edge d_r_valid", d_bus.r_valid, 1);
    check("edge d_r_resp", d_bus.r_resp, 2'b00);
    check("edge d_r_data", d_bus.r_data, 64'h7777_7777_0000_0007);
    step();
    m_bus.r_valid = 1'b0;
    #1;
    check("edge no ERR after", d_bus.r_valid, 0);
    step();

    // Reset asserted in DATA.
    i_bus.ar_valid = 1'b1; i_bus.ar_addr = 64'h8000_4000;
    step();
    i_bus.ar_valid = 1'b0; m_bus.ar_ready = 1'b1;
    step();
    m_bus.ar_ready = 1'b0;
    #1;
    check("rst-pre m_ar_addr", m_bus.ar_addr, 64'h8000_4000);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    check_reset("mid-rst");
    d_bus.ar_valid = 1'b1; d_bus.ar_addr = 64'h8000_5000;
    #1;
    check("post-rst d_ar_ready", d_bus.ar_ready, 1);
    check("post-rst i_ar_ready", i_bus.ar_ready, 0);
    step();
    d_bus.ar_valid = 1'b0; m_bus.ar_ready = 1'b1;
    #1;
    check("post-rst m_ar_id", m_bus.ar_id, 0);
    check("post-rst m_ar_addr", m_bus.ar_addr, 64'h8000_5000);
    step();
    m_bus.ar_ready = 1'b0;
    beat(64'h5000_5000_5000_5000, 4'd0, 1'b1, 2'b00);
    #1;
    check("post-rst d_r_valid", d_bus.r_valid, 1);
    check("post-rst d_r_data", d_bus.r_data, 64'h5000_5000_5000_5000);
    step();
    m_bus.r_valid = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
